sensor_frame_rx: RTL and testbench

- Receive-side stage between uart_rx and the arbiter's result path.
- After the arbiter sends a sensor request over tx, this block consumes the byte stream from uart_rx (rx_DV/rx_Byte) and assembles a 5-byte sensor response frame.
- Validates sensor ID and checksum, enforces a response timeout, then presents a 32-bit result with a one-cycle done pulse.

---
 rtl/sensor_frame_rx.sv | 142 ++++++++++++++
 tb/tb_sensor_frame_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_rx.sv
// Assembles a 5-byte sensor response (id, status, data_hi, data_lo, xor checksum)
// after an arbiter request, with ID/checksum validation and a response timeout.
module sensor_frame_rx #(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int TO_WIDTH       = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_en,
  input  logic        start,
  input  logic [7:0]  req_id,
  input  logic        rx_DV,
  input  logic [7:0]  rx_Byte,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err_timeout,
  output logic        err_checksum,
  output logic        err_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

  logic [1:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [TO_WIDTH-1:0] timer_q, timer_d, timer_inc;
  logic [7:0]          acc_q, acc_d;
  logic [7:0]          id_q, id_d;
  logic [3:0][7:0]     buf_q, buf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         result_q, result_d;
  logic                eto_q, eto_d;
  logic                ecs_q, ecs_d;
  logic                eid_q, eid_d;

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    acc_d    = acc_q;
    id_d     = id_q;
    buf_d    = buf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    eto_d    = eto_q;
    ecs_d    = ecs_q;
    eid_d    = eid_q;
    case (state_q)
      IDLE: begin
        // Bytes arriving outside a window (including alongside start) are dropped.
        if (start) begin
          id_d    = req_id;
          cnt_d   = 3'd0;
          timer_d = '0;
          acc_d   = 8'h00;
          eto_d   = 1'b0;
          ecs_d   = 1'b0;
          eid_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (rx_DV) begin
          if (cnt_q != 3'd4) buf_d[cnt_q[1:0]] = rx_Byte;
          acc_d   = acc_q ^ rx_Byte;
          cnt_d   = cnt_q + 3'd1;
          timer_d = '0;
          if (cnt_q == 3'd4) state_d = CHECK;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TO_LIMIT) begin
            done_d   = 1'b1;
            eto_d    = 1'b1;
            result_d = 32'h0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      CHECK: begin
        ecs_d    = (acc_q != 8'h00);
        eid_d    = (buf_q[0] != id_q);
        result_d = ((acc_q == 8'h00) && (buf_q[0] == id_q)) ?
                   {buf_q[0], buf_q[1], buf_q[2], buf_q[3]} : 32'h0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      timer_q  <= '0;
      acc_q    <= 8'h00;
      id_q     <= 8'h00;
      buf_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
      eto_q    <= 1'b0;
      ecs_q    <= 1'b0;
      eid_q    <= 1'b0;
    end else if (clock_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      acc_q    <= acc_d;
      id_q     <= id_d;
      buf_q    <= buf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      eto_q    <= eto_d;
      ecs_q    <= ecs_d;
      eid_q    <= eid_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign err_timeout  = eto_q;
  assign err_checksum = ecs_q;
  assign err_id       = eid_q;

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Directed bench for sensor_frame_rx with a short timeout (100 cycles).
module tb_sensor_frame_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clock_en = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  req_id = 8'h00;
  logic        rx_DV = 1'b0;
  logic [7:0]  rx_Byte = 8'h00;
  logic        busy, done, err_timeout, err_checksum, err_id;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int base;

  sensor_frame_rx #(.TIMEOUT_CYCLES(100), .TO_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en), .start(start),
    .req_id(req_id), .rx_DV(rx_DV), .rx_Byte(rx_Byte), .busy(busy),
    .done(done), .result(result), .err_timeout(err_timeout),
    .err_checksum(err_checksum), .err_id(err_id)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [7:0] id);
    start = 1'b1; req_id = id;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_DV = 1'b1; rx_Byte = b;
    tick();
    rx_DV = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, b3, b4);
    send(b0); send(b1); send(b2); send(b3); send(b4);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res,
                         input logic eto, input logic ecs, input logic eid);
    chk({tag, ".done"},   {31'b0, done}, 32'd1);
    chk({tag, ".busy"},   {31'b0, busy}, 32'd0);
    chk({tag, ".result"}, result, res);
    chk({tag, ".err"},    {29'b0, err_timeout, err_checksum, err_id}, {29'b0, eto, ecs, eid});
  endtask

  initial begin
    #12;
    chk("reset.outs", {busy, done, err_timeout, err_checksum, err_id}, 32'd0);
    chk("reset.result", result, 32'h0);
    reset = 1'b0;
    tick();

    // 1: good frame
    do_start(8'h01);
    chk("t1.busy_open", {31'b0, busy}, 32'd1);
    base = done_cnt;
    frame(8'h01, 8'h00, 8'h12, 8'h34, 8'h27);
    chk("t1.no_done_at_N", {31'b0, done}, 32'd0);
    tick();
    chk_out("t1", 32'h01001234, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t1.done_drop", {31'b0, done}, 32'd0);
    chk("t1.result_hold", result, 32'h01001234);
    chk("t1.one_done", done_cnt - base, 32'd1);

    // 2: bad checksum
    do_start(8'h01);
    frame(8'h01, 8'h00, 8'h12, 8'h34, 8'h28);
    tick();
    chk_out("t2", 32'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // 3: ID mismatch with a valid checksum
    do_start(8'h01);
    chk("t3.err_cleared", {29'b0, err_timeout, err_checksum, err_id}, 32'd0);
    frame(8'h02, 8'h00, 8'h12, 8'h34, 8'h24);
    tick();
    chk_out("t3", 32'h0, 1'b0, 1'b0, 1'b1);
    tick();

    // 4: timeout 100 enabled edges after the second byte
    do_start(8'h01);
    send(8'h01); send(8'h00);
    repeat (99) tick();
    chk("t4.no_early_to", {31'b0, done}, 32'd0);
    chk("t4.busy_before", {31'b0, busy}, 32'd1);
    tick();
    chk_out("t4", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();

    // byte on the expiring edge wins
    do_start(8'h01);
    repeat (99) tick();
    send(8'h01);
    chk("exp.no_to", {30'b0, done, err_timeout}, 32'd0);
    send(8'h00); send(8'h12); send(8'h34); send(8'h27);
    tick();
    chk_out("exp", 32'h01001234, 1'b0, 1'b0, 1'b0);
    tick();

    // clock_en: strobe while disabled is lost, done is frozen high
    do_start(8'h01);
    send(8'h01);
    clock_en = 1'b0;
    send(8'h55);
    clock_en = 1'b1;
    send(8'h00); send(8'h12); send(8'h34); send(8'h27);
    tick();
    chk_out("cen", 32'h01001234, 1'b0, 1'b0, 1'b0);
    clock_en = 1'b0;
    repeat (3) tick();
    chk("cen.done_frozen", {31'b0, done}, 32'd1);
    clock_en = 1'b1;
    tick();
    chk("cen.done_drop", {31'b0, done}, 32'd0);

    // 5: reset after the 3rd byte
    do_start(8'h01);
    send(8'h01); send(8'h00); send(8'h12);
    base = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("t5.busy", {31'b0, busy}, 32'd0);
    chk("t5.result", result, 32'h0);
    chk("t5.errs", {30'b0, done, err_timeout}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("t5.no_done", done_cnt - base, 32'd0);
    do_start(8'h01);
    frame(8'h01, 8'h00, 8'h12, 8'h34, 8'h27);
    tick();
    chk_out("t5b", 32'h01001234, 1'b0, 1'b0, 1'b0);
    tick();

    // 6: stray byte, start with a simultaneous byte, second start mid-frame
    base = done_cnt;
    send(8'hAA);
    chk("t6.idle_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; req_id = 8'h01; rx_DV = 1'b1; rx_Byte = 8'h01;
    tick();
    start = 1'b0; rx_DV = 1'b0;
    send(8'h01); send(8'h00);
    start = 1'b1; req_id = 8'h02;
    tick();
    start = 1'b0;
    send(8'h12); send(8'h34); send(8'h27);
    tick();
    chk_out("t6", 32'h01001234, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t6.one_done", done_cnt - base, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
